// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
//
// Single-cycle RV32I integer / jump / branch execution unit. It sits between
// the reservation station issue port and the ALU half of the common data bus.
// One instruction may be accepted per cycle. The result, the destination ROB
// alias and the branch/jump resolution are registered, so they appear one
// cycle after issue. There is no backpressure.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   rdy                 : global ready; low freezes every output register
//   rollback_signal     : ROB flush; clears outputs and drops the issue
//   optype_from_rs      : issued operation (OP_NOP = no issue)
//   rd_from_rs          : destination ROB alias
//   pc_from_rs          : instruction PC
//   Vi_from_rs          : rs1 value
//   Vj_from_rs          : rs2 value
//   imm_from_rs         : sign-extended immediate (pre-shifted for LUI/AUIPC)
//   alu_has_result      : CDB valid
//   alu_alias           : ROB alias of the result
//   alu_result          : value written to rd
//   alu_is_jump         : op was a branch, JAL or JALR
//   alu_taken           : control transfer taken
//   alu_target_pc       : resolved target PC
//
// Optype encodings (shared with the rest of the core):
//   0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BEQ, 6 BNE, 7 BLT, 8 BGE,
//   9 BLTU, 10 BGEU, 11-15 loads, 16-18 stores, 19 ADDI, 20 SLTI,
//   21 SLTIU, 22 XORI, 23 ORI, 24 ANDI, 25 SLLI, 26 SRLI, 27 SRAI,
//   28 ADD, 29 SUB, 30 SLL, 31 SLT, 32 SLTU, 33 XOR, 34 SRL, 35 SRA,
//   36 OR, 37 AND. Loads, stores and 38-63 are handled as NOP.
// ---------------------------------------------------------------------------
module alu_unit #(
    parameter int OP_W     = 6,
    parameter int ROB_ID_W = 5,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                rollback_signal,
    input  logic [OP_W-1:0]     optype_from_rs,
    input  logic [ROB_ID_W-1:0] rd_from_rs,
    input  logic [XLEN-1:0]     pc_from_rs,
    input  logic [XLEN-1:0]     Vi_from_rs,
    input  logic [XLEN-1:0]     Vj_from_rs,
    input  logic [XLEN-1:0]     imm_from_rs,
    output logic                alu_has_result,
    output logic [ROB_ID_W-1:0] alu_alias,
    output logic [XLEN-1:0]     alu_result,
    output logic                alu_is_jump,
    output logic                alu_taken,
    output logic [XLEN-1:0]     alu_target_pc
);

    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'd1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(6'd2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'd3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(6'd4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'd5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'd6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(6'd7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(6'd8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(6'd9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(6'd10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'd19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'd20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'd21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'd22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'd23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'd24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(6'd25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(6'd26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(6'd27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'd28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'd29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'd30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6'd31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(6'd32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6'd33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6'd34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(6'd35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6'd36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'd37);

    localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};

    // Shared operands and comparators
    logic            is_rtype_s;
    logic [XLEN-1:0] op2_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] pc_imm_s;
    logic [XLEN-1:0] vi_imm_s;
    logic            slt_s;
    logic            sltu_s;
    logic            br_eq_s;
    logic            br_lt_s;
    logic            br_ltu_s;

    // Next-cycle output values
    logic                valid_s;
    logic [XLEN-1:0]     result_s;
    logic                is_jump_s;
    logic                taken_s;
    logic [XLEN-1:0]     target_s;

    // Output registers
    logic                has_result_r;
    logic [ROB_ID_W-1:0] alias_r;
    logic [XLEN-1:0]     result_r;
    logic                is_jump_r;
    logic                taken_r;
    logic [XLEN-1:0]     target_r;

    // R-type ops (ADD..AND) take rs2 as second operand, all others take imm
    assign is_rtype_s = (optype_from_rs >= OP_ADD) && (optype_from_rs <= OP_AND);
    assign op2_s      = is_rtype_s ? Vj_from_rs : imm_from_rs;
    assign shamt_s    = op2_s[4:0];
    assign pc_plus4_s = pc_from_rs + PC_STEP;
    assign pc_imm_s   = pc_from_rs + imm_from_rs;
    assign vi_imm_s   = Vi_from_rs + imm_from_rs;
    assign slt_s      = $signed(Vi_from_rs) < $signed(op2_s);
    assign sltu_s     = Vi_from_rs < op2_s;
    assign br_eq_s    = Vi_from_rs == Vj_from_rs;
    assign br_lt_s    = $signed(Vi_from_rs) < $signed(Vj_from_rs);
    assign br_ltu_s   = Vi_from_rs < Vj_from_rs;

    // Decode the issued op into the values the output registers will load
    always_comb begin
        valid_s   = 1'b0;
        result_s  = XLEN_ZERO;
        is_jump_s = 1'b0;
        taken_s   = 1'b0;
        target_s  = XLEN_ZERO;
        case (optype_from_rs)
            OP_ADD, OP_ADDI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs + op2_s;
            end
            OP_SUB: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs - Vj_from_rs;
            end
            OP_AND, OP_ANDI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs & op2_s;
            end
            OP_OR, OP_ORI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs | op2_s;
            end
            OP_XOR, OP_XORI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs ^ op2_s;
            end
            OP_SLT, OP_SLTI: begin
                valid_s  = 1'b1;
                result_s = {{(XLEN-1){1'b0}}, slt_s};
            end
            OP_SLTU, OP_SLTIU: begin
                valid_s  = 1'b1;
                result_s = {{(XLEN-1){1'b0}}, sltu_s};
            end
            OP_SLL, OP_SLLI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs << shamt_s;
            end
            OP_SRL, OP_SRLI: begin
                valid_s  = 1'b1;
                result_s = Vi_from_rs >> shamt_s;
            end
            OP_SRA, OP_SRAI: begin
                valid_s  = 1'b1;
                result_s = $unsigned($signed(Vi_from_rs) >>> shamt_s);
            end
            OP_LUI: begin
                valid_s  = 1'b1;
                result_s = imm_from_rs;
            end
            OP_AUIPC: begin
                valid_s  = 1'b1;
                result_s = pc_imm_s;
            end
            OP_JAL: begin
                valid_s   = 1'b1;
                result_s  = pc_plus4_s;
                is_jump_s = 1'b1;
                taken_s   = 1'b1;
                target_s  = pc_imm_s;
            end
            OP_JALR: begin
                valid_s   = 1'b1;
                result_s  = pc_plus4_s;
                is_jump_s = 1'b1;
                taken_s   = 1'b1;
                target_s  = {vi_imm_s[XLEN-1:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                valid_s   = 1'b1;
                is_jump_s = 1'b1;
                case (optype_from_rs)
                    OP_BEQ:  taken_s = br_eq_s;
                    OP_BNE:  taken_s = !br_eq_s;
                    OP_BLT:  taken_s = br_lt_s;
                    OP_BGE:  taken_s = !br_lt_s;
                    OP_BLTU: taken_s = br_ltu_s;
                    OP_BGEU: taken_s = !br_ltu_s;
                    default: taken_s = 1'b0;
                endcase
                if (taken_s) begin
                    target_s = pc_imm_s;
                end else begin
                    target_s = pc_plus4_s;
                end
            end
            // NOP, loads, stores and undefined encodings: no broadcast
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Output registers: reset > rollback flush > pause hold > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_result_r <= 1'b0;
            alias_r      <= {ROB_ID_W{1'b0}};
            result_r     <= XLEN_ZERO;
            is_jump_r    <= 1'b0;
            taken_r      <= 1'b0;
            target_r     <= XLEN_ZERO;
        end else if (rollback_signal) begin
            has_result_r <= 1'b0;
            alias_r      <= {ROB_ID_W{1'b0}};
            result_r     <= XLEN_ZERO;
            is_jump_r    <= 1'b0;
            taken_r      <= 1'b0;
            target_r     <= XLEN_ZERO;
        end else if (!rdy) begin
            has_result_r <= has_result_r;
            alias_r      <= alias_r;
            result_r     <= result_r;
            is_jump_r    <= is_jump_r;
            taken_r      <= taken_r;
            target_r     <= target_r;
        end else begin
            has_result_r <= valid_s;
            // Invalid cycles drive alias/result to 0 rather than stale data
            alias_r      <= valid_s ? rd_from_rs : {ROB_ID_W{1'b0}};
            result_r     <= result_s;
            is_jump_r    <= is_jump_s;
            taken_r      <= taken_s;
            target_r     <= target_s;
        end
    end

    assign alu_has_result = has_result_r;
    assign alu_alias      = alias_r;
    assign alu_result     = result_r;
    assign alu_is_jump    = is_jump_r;
    assign alu_taken      = taken_r;
    assign alu_target_pc  = target_r;

endmodule
